// File: rtl/framebuffer_scanout.sv
`default_nettype none
// ============================================================================
// Module   : framebuffer_scanout
// Purpose  : Display-side framebuffer reader. Generates video timing, turns
//            the screen position into a downscaled framebuffer address without
//            a multiplier, hides the 2-cycle read latency and delivers RGB888
//            with aligned hsync/vsync/active.
// Revision : 1.0  initial release
// ============================================================================
module framebuffer_scanout #(
  parameter int FB_WIDTH   = 320,
  parameter int FB_HEIGHT  = 180,
  parameter int SCALE_LOG2 = 2,
  parameter int COLOR_BITS = 16,
  parameter int ADDR_BITS  = 16,
  parameter int H_ACTIVE   = 1280,
  parameter int H_FP       = 110,
  parameter int H_SYNC     = 40,
  parameter int H_BP       = 220,
  parameter int V_ACTIVE   = 720,
  parameter int V_FP       = 5,
  parameter int V_SYNC     = 5,
  parameter int V_BP       = 20,
  parameter bit SYNC_POL   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ADDR_BITS-1:0]  read_addr,
  input  logic [COLOR_BITS-1:0] read_data,
  output logic [7:0]            red,
  output logic [7:0]            green,
  output logic [7:0]            blue,
  output logic                  hsync,
  output logic                  vsync,
  output logic                  active,
  output logic                  frame_done
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HCW      = $clog2(H_TOTAL);
  localparam int VCW      = $clog2(V_TOTAL);
  localparam int SUB_MASK = (1 << SCALE_LOG2) - 1;
  localparam int WIN_W    = FB_WIDTH << SCALE_LOG2;
  localparam int WIN_H    = FB_HEIGHT << SCALE_LOG2;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;

  // Stage 0: position counters and incremental address components
  logic [HCW-1:0]       hcount_q, hcount_d;
  logic [VCW-1:0]       vcount_q, vcount_d;
  logic [ADDR_BITS-1:0] col_q, col_d;
  logic [ADDR_BITS-1:0] row_base_q, row_base_d;
  logic                 frame_done_q, frame_done_d;

  // Stage 1..3 flag delay line (index 0 = stage 1)
  logic [2:0]           act_q, hs_q, vs_q, win_q;
  logic [ADDR_BITS-1:0] read_addr_q;

  // Stage 4 output registers
  logic [7:0]           red_q, green_q, blue_q;
  logic                 hsync_q, vsync_q, active_q;

  logic [31:0] w_h32, w_v32, w_hd32, w_vd32;
  logic        w_h_last, w_v_last, w_h_sub_last, w_v_sub_last;
  logic        w_act0, w_hs0, w_vs0, w_win0;
  logic [4:0]  w_r5, w_b5;
  logic [5:0]  w_g6;

  assign w_h32        = 32'(hcount_q);
  assign w_v32        = 32'(vcount_q);
  assign w_h_last     = (w_h32 == H_TOTAL - 1);
  assign w_v_last     = (w_v32 == V_TOTAL - 1);
  // Last pixel / last line of a 2^SCALE_LOG2 block
  assign w_h_sub_last = ((w_h32 & SUB_MASK) == SUB_MASK);
  assign w_v_sub_last = ((w_v32 & SUB_MASK) == SUB_MASK);

  assign w_act0 = (w_h32 < H_ACTIVE) && (w_v32 < V_ACTIVE);
  assign w_hs0  = (w_h32 >= HS_START) && (w_h32 < HS_END);
  assign w_vs0  = (w_v32 >= VS_START) && (w_v32 < VS_END);
  assign w_win0 = (w_h32 < WIN_W) && (w_v32 < WIN_H);

  // Next-state for counters, column index and row base (no multiplier)
  always_comb begin
    hcount_d   = hcount_q + HCW'(1);
    vcount_d   = vcount_q;
    col_d      = col_q;
    row_base_d = row_base_q;
    if (w_h_last) begin
      hcount_d = '0;
      col_d    = '0;
      if (w_v_last) begin
        vcount_d   = '0;
        row_base_d = '0;
      end else begin
        vcount_d = vcount_q + VCW'(1);
        if (w_v_sub_last) begin
          row_base_d = row_base_q + ADDR_BITS'(FB_WIDTH);
        end
      end
    end else if (w_h_sub_last) begin
      col_d = col_q + ADDR_BITS'(1);
    end
  end

  // frame_done is decoded from next-state so it lines up with the counters
  assign w_hd32       = 32'(hcount_d);
  assign w_vd32       = 32'(vcount_d);
  assign frame_done_d = (w_hd32 == H_ACTIVE - 1) && (w_vd32 == V_ACTIVE - 1);

  // Stage 0 registers: counters, address components, frame_done
  always_ff @(posedge clk) begin
    if (rst) begin
      hcount_q     <= '0;
      vcount_q     <= '0;
      col_q        <= '0;
      row_base_q   <= '0;
      frame_done_q <= 1'b0;
    end else begin
      hcount_q     <= hcount_d;
      vcount_q     <= vcount_d;
      col_q        <= col_d;
      row_base_q   <= row_base_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Stage 1 address register (holds outside the window) and flag delay line
  always_ff @(posedge clk) begin
    if (rst) begin
      read_addr_q <= '0;
      act_q       <= '0;
      hs_q        <= '0;
      vs_q        <= '0;
      win_q       <= '0;
    end else begin
      if (w_win0) begin
        read_addr_q <= row_base_q + col_q;
      end
      act_q <= {act_q[1:0], w_act0};
      hs_q  <= {hs_q[1:0], w_hs0};
      vs_q  <= {vs_q[1:0], w_vs0};
      win_q <= {win_q[1:0], w_win0};
    end
  end

  // RGB565 to RGB888 by MSB replication
  assign w_r5 = read_data[15:11];
  assign w_g6 = read_data[10:5];
  assign w_b5 = read_data[4:0];

  // Stage 4: colors and syncs registered together; blank/out-of-window is black
  always_ff @(posedge clk) begin
    if (rst) begin
      red_q    <= '0;
      green_q  <= '0;
      blue_q   <= '0;
      active_q <= 1'b0;
      hsync_q  <= !SYNC_POL;
      vsync_q  <= !SYNC_POL;
    end else begin
      active_q <= act_q[2];
      hsync_q  <= hs_q[2] ? SYNC_POL : !SYNC_POL;
      vsync_q  <= vs_q[2] ? SYNC_POL : !SYNC_POL;
      if (act_q[2] && win_q[2]) begin
        red_q   <= {w_r5, w_r5[4:2]};
        green_q <= {w_g6, w_g6[5:4]};
        blue_q  <= {w_b5, w_b5[4:2]};
      end else begin
        red_q   <= '0;
        green_q <= '0;
        blue_q  <= '0;
      end
    end
  end

  assign read_addr  = read_addr_q;
  assign red        = red_q;
  assign green      = green_q;
  assign blue       = blue_q;
  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign active     = active_q;
  assign frame_done = frame_done_q;

endmodule
`default_nettype wire
